// File: rtl/index_encoder.sv
// ---------------------------------------------------------------------------
// index_encoder
//
// Converts a captured 16-bit enable/one-hot vector back into 4-bit indices.
// A vector is taken on the input valid/ready handshake. The index of each set
// bit is then emitted in ascending order, one per output handshake, together
// with last/error flags and the vector's population count.
//
// Parameters
//   STRICT     0: serialize every set bit
//              1: one-hot check mode, exactly one beat per vector
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   in_vec is valid
//   in_ready   block can accept a vector (high exactly when idle)
//   in_vec     enable vector, bit i <-> index i
//   out_valid  out_idx/out_last/out_err/out_cnt are valid
//   out_ready  downstream consumes the beat
//   out_idx    index of the current set bit (0 when none)
//   out_last   final beat for the captured vector
//   out_err    vector not exactly one-hot (zero, or multi-hot when STRICT=1)
//   out_cnt    popcount of the captured vector, 0..16
// ---------------------------------------------------------------------------
module index_encoder #(
   parameter bit STRICT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_vec,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_idx,
   output logic        out_last,
   output logic        out_err,
   output logic [4:0]  out_cnt
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t      state, state_nxt;
   logic [15:0] rem;       // bits not yet emitted
   logic [4:0]  cnt;       // popcount of the captured vector
   logic        err;       // captured vector is not a valid one-hot
   logic [4:0]  in_cnt;
   logic [3:0]  low_idx;
   logic        rem_le1;   // rem has at most one bit set

   function automatic logic [4:0] popcount(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
      return n;
   endfunction

   assign in_cnt = popcount(in_vec);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      low_idx = '0;
      for (int i = 15; i >= 0; i--) begin
         if (rem[i]) low_idx = 4'(i);
      end
   end

   // Clearing the lowest set bit leaves zero exactly when at most one bit was
   // set; rem==0 also lands here since 0 & 16'hFFFF is zero.
   assign rem_le1 = ((rem & (rem - 16'd1)) == 16'd0);

   // NOTE: state elements use non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_idx   = '0;
      out_last  = 1'b0;
      out_err   = 1'b0;
      out_cnt   = '0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = EMIT;
         end
         EMIT: begin
            out_valid = 1'b1;
            out_idx   = low_idx;
            out_last  = STRICT ? 1'b1 : rem_le1;
            out_err   = err;
            out_cnt   = cnt;
            if (out_ready && out_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are built only from rem/cnt/err, so they hold still while a beat
   // is stalled and in_vec never reaches them combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem <= '0;
         cnt <= '0;
         err <= 1'b0;
      end else if (in_valid && in_ready) begin
         rem <= in_vec;
         cnt <= in_cnt;
         err <= STRICT ? (in_cnt != 5'd1) : (in_vec == 16'd0);
      end else if (out_valid && out_ready) begin
         // The final beat empties rem so the idle state starts clean.
         rem <= out_last ? 16'd0 : (rem & (rem - 16'd1));
      end
   end

endmodule

// File: tb/tb_index_encoder.sv
// ---------------------------------------------------------------------------
// tb_index_encoder
//
// Drives one instance per STRICT value. Each accepted vector pushes its
// expected beats into a queue; beats popped as the DUT hands them off.
// ---------------------------------------------------------------------------
module tb_index_encoder;

   typedef struct packed {
      logic [3:0] idx;
      logic       last;
      logic       err;
      logic [4:0] cnt;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;

   logic        iv0, ir0, ov0, ordy0, last0, err0;
   logic [15:0] vec0;
   logic [3:0]  idx0;
   logic [4:0]  cnt0;

   logic        iv1, ir1, ov1, ordy1, last1, err1;
   logic [15:0] vec1;
   logic [3:0]  idx1;
   logic [4:0]  cnt1;

   index_encoder #(.STRICT(1'b0)) dut0 (
      .clk(clk), .rst(rst),
      .in_valid(iv0), .in_ready(ir0), .in_vec(vec0),
      .out_valid(ov0), .out_ready(ordy0), .out_idx(idx0),
      .out_last(last0), .out_err(err0), .out_cnt(cnt0)
   );

   index_encoder #(.STRICT(1'b1)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(iv1), .in_ready(ir1), .in_vec(vec1),
      .out_valid(ov1), .out_ready(ordy1), .out_idx(idx1),
      .out_last(last1), .out_err(err1), .out_cnt(cnt1)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   int    last_cycles;
   beat_t exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic beat_t get_obs(input bit sel);
      beat_t b;
      if (sel) b = {idx1, last1, err1, cnt1};
      else     b = {idx0, last0, err0, cnt0};
      return b;
   endfunction

   // Reference model: expected beat list for one vector.
   task automatic push_model(input bit sel, input logic [15:0] vec);
      int    ones;
      int    left;
      int    low;
      beat_t b;
      ones = 0;
      low  = 0;
      for (int i = 0; i < 16; i++) ones += int'(vec[i]);
      for (int i = 15; i >= 0; i--) if (vec[i]) low = i;
      if (sel) begin
         b.idx = 4'(low); b.last = 1'b1; b.err = (ones != 1); b.cnt = 5'(ones);
         exp_q.push_back(b);
      end else if (ones == 0) begin
         b.idx = 4'd0; b.last = 1'b1; b.err = 1'b1; b.cnt = 5'd0;
         exp_q.push_back(b);
      end else begin
         left = ones;
         for (int i = 0; i < 16; i++) begin
            if (vec[i]) begin
               left--;
               b.idx = 4'(i); b.last = (left == 0); b.err = 1'b0; b.cnt = 5'(ones);
               exp_q.push_back(b);
            end
         end
      end
   endtask

   // Accept one vector; returns #1 after the capturing edge.
   task automatic send(input bit sel, input logic [15:0] vec);
      @(negedge clk);
      chk("in_ready_before_accept", 32'(sel ? ir1 : ir0), 32'd1);
      if (sel) begin iv1 = 1'b1; vec1 = vec; end
      else     begin iv0 = 1'b1; vec0 = vec; end
      @(posedge clk);
      #1;
      if (sel) iv1 = 1'b0;
      else     iv0 = 1'b0;
      push_model(sel, vec);
   endtask

   // Consume nbeats beats; rnd toggles out_ready pseudo-randomly.
   task automatic collect(input bit sel, input int nbeats, input bit rnd);
      int    got;
      int    cyc;
      bit    rdy;
      bit    stalled;
      bit    ov;
      beat_t obs;
      beat_t held;
      got     = 0;
      cyc     = 0;
      stalled = 1'b0;
      held    = '0;
      while (got < nbeats && cyc < 400) begin
         @(negedge clk);
         cyc++;
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (sel) ordy1 = rdy;
         else     ordy0 = rdy;
         ov  = sel ? ov1 : ov0;
         obs = get_obs(sel);
         if (stalled) begin
            chk("stall_valid_held", 32'(ov), 32'd1);
            chk("stall_outputs_stable", 32'(obs), 32'(held));
         end
         if (ov && exp_q.size() > 0) begin
            chk("beat", 32'(obs), 32'(exp_q[0]));
            if (rdy) begin
               void'(exp_q.pop_front());
               got++;
               stalled = 1'b0;
            end else begin
               held    = obs;
               stalled = 1'b1;
            end
         end
      end
      chk("beats_before_timeout", 32'(got), 32'(nbeats));
      last_cycles = cyc;
   endtask

   initial begin
      rst   = 1'b1;
      iv0   = 1'b0; iv1 = 1'b0;
      vec0  = '0;   vec1 = '0;
      ordy0 = 1'b0; ordy1 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready0", 32'(ir0), 32'd1);
      chk("reset_out_valid0", 32'(ov0), 32'd0);
      chk("reset_outputs0", 32'(get_obs(1'b0)), 32'd0);
      chk("reset_in_ready1", 32'(ir1), 32'd1);
      chk("reset_out_valid1", 32'(ov1), 32'd0);
      chk("reset_outputs1", 32'(get_obs(1'b1)), 32'd0);
      rst = 1'b0;

      // Single one-hot: one beat, idle again two cycles after accept.
      send(1'b0, 16'h0008);
      collect(1'b0, 1, 1'b0);
      chk("onehot_latency", 32'(last_cycles), 32'd1);
      @(negedge clk);
      chk("onehot_in_ready_after", 32'(ir0), 32'd1);
      chk("onehot_out_valid_after", 32'(ov0), 32'd0);

      // Four bits, back-to-back beats.
      send(1'b0, 16'h8421);
      collect(1'b0, 4, 1'b0);
      chk("multi_consecutive", 32'(last_cycles), 32'd4);
      @(negedge clk);
      chk("multi_in_ready_after", 32'(ir0), 32'd1);

      // All ones under random backpressure.
      send(1'b0, 16'hFFFF);
      collect(1'b0, 16, 1'b1);
      chk("full_drain", 32'(exp_q.size()), 32'd0);

      // Zero vector in both modes.
      send(1'b0, 16'h0000);
      collect(1'b0, 1, 1'b0);
      send(1'b1, 16'h0000);
      collect(1'b1, 1, 1'b0);

      // STRICT multi-hot, stalled while another vector is offered.
      send(1'b1, 16'h0006);
      ordy1 = 1'b0;
      iv1   = 1'b1;
      vec1  = 16'h0100;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("busy_in_ready", 32'(ir1), 32'd0);
         chk("busy_idx", 32'(idx1), 32'd1);
      end
      iv1 = 1'b0;
      collect(1'b1, 1, 1'b0);
      @(negedge clk);
      chk("busy_no_extra_beat", 32'(ov1), 32'd0);
      chk("busy_idle_again", 32'(ir1), 32'd1);

      send(1'b1, 16'h4000);
      collect(1'b1, 1, 1'b0);

      // Reset in the middle of a sequence.
      send(1'b0, 16'hFFFF);
      collect(1'b0, 3, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midreset_out_valid", 32'(ov0), 32'd0);
      chk("midreset_in_ready", 32'(ir0), 32'd1);
      chk("midreset_outputs", 32'(get_obs(1'b0)), 32'd0);
      rst = 1'b0;
      exp_q.delete();
      send(1'b0, 16'h0010);
      collect(1'b0, 1, 1'b0);
      chk("final_drain", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
